// File: rtl/argmax_serializer.sv
// argmax_serializer
//   Takes one parallel vector of CELL_AMOUNT signed accumulator scores per
//   handshake, requantizes every score to an unsigned DATA_WIDTH value
//   (arithmetic shift by SHIFT, then clamp to [0, 2^DATA_WIDTH-1]) and
//   streams the results out one per cycle as (index, value, enable) for the
//   argmax stage. Two vector slots (ACTIVE, PENDING) allow back-to-back
//   vectors with no bubble between them.
//
// Ports
//   clk, rst_n  clock / asynchronous active-low reset
//   in_valid    vector present on in_data
//   in_ready    vector can be taken this cycle (PENDING slot free)
//   in_data     score i at [i*ACC_WIDTH +: ACC_WIDTH], two's complement
//   out_enable  out_index / out_value valid this cycle
//   out_index   score index 0..CELL_AMOUNT-1
//   out_value   requantized score
//   busy        ACTIVE or PENDING slot occupied

// Per-lane requantizer: clamp(x >>> SHIFT, 0, 2^DATA_WIDTH-1).
module argmax_serializer_quant #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int SHIFT      = 8
) (
  input  logic [ACC_WIDTH-1:0]  x,
  output logic [DATA_WIDTH-1:0] value
);
  // Work width leaves room for a sign bit above the widest of the two
  // operands, so neither the shift nor the range test can wrap.
  localparam int QW = ((ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH) + 2;

  logic signed [QW-1:0] ext;
  logic signed [QW-1:0] s;
  logic                 neg;
  logic                 over;

  assign ext  = {{(QW-ACC_WIDTH){x[ACC_WIDTH-1]}}, x};
  assign s    = ext >>> SHIFT;
  assign neg  = s[QW-1];
  // Any set bit between the sign and the kept field means s > 2^DATA_WIDTH-1.
  assign over = |s[QW-2:DATA_WIDTH];

  always_comb begin
    value = s[DATA_WIDTH-1:0];
    if (neg)       value = '0;
    else if (over) value = '1;
  end
endmodule

module argmax_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int INDEX_WIDTH = 10,
  parameter int CELL_AMOUNT = 4,
  parameter int SHIFT       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CELL_AMOUNT*ACC_WIDTH-1:0] in_data,
  output logic                             out_enable,
  output logic [INDEX_WIDTH-1:0]           out_index,
  output logic [DATA_WIDTH-1:0]            out_value,
  output logic                             busy
);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(CELL_AMOUNT - 1);

  typedef logic [CELL_AMOUNT-1:0][ACC_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, STREAM} state_t;

  state_t                                state;
  vec_t                                  active;
  vec_t                                  pending;
  logic                                  pending_valid;
  logic [INDEX_WIDTH-1:0]                idx;
  logic [CELL_AMOUNT-1:0][DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0]                 q_sel;
  logic                                  active_valid;
  logic                                  accept;
  logic                                  last;

  // ACTIVE holds a vector exactly while streaming.
  assign active_valid = (state == STREAM);
  assign in_ready     = !pending_valid;
  assign busy         = active_valid || pending_valid;
  assign accept       = in_valid && in_ready;
  assign last         = (idx == LAST_IDX);

  for (genvar i = 0; i < CELL_AMOUNT; i++) begin : g_lane
    argmax_serializer_quant #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT      (SHIFT)
    ) u_quant (
      .x     (active[i]),
      .value (q[i])
    );
  end

  // Compare-based select keeps the mux free of index-width mismatches.
  always_comb begin
    q_sel = '0;
    for (int i = 0; i < CELL_AMOUNT; i++)
      if (idx == INDEX_WIDTH'(i)) q_sel = q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      idx           <= '0;
      out_enable    <= 1'b0;
      out_index     <= '0;
      out_value     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_enable <= 1'b0;
          out_index  <= '0;
          out_value  <= '0;
          idx        <= '0;
          if (accept) begin
            active <= vec_t'(in_data);
            state  <= STREAM;
          end
        end
        STREAM: begin
          out_enable <= 1'b1;
          out_index  <= idx;
          out_value  <= q_sel;
          if (!last) begin
            idx <= idx + INDEX_WIDTH'(1);
            if (accept) begin
              pending       <= vec_t'(in_data);
              pending_valid <= 1'b1;
            end
          end else begin
            idx <= '0;
            // accept cannot coincide with a full PENDING (in_ready is low).
            if (pending_valid) begin
              active        <= pending;
              pending_valid <= 1'b0;
            end else if (accept) begin
              active <= vec_t'(in_data);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_serializer.sv
module tb_argmax_serializer;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int IW = 10;
  localparam int CA = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [CA*AW-1:0] in_data;
  logic          in_ready, in_ready4;
  logic          out_enable, out_enable4;
  logic [IW-1:0] out_index, out_index4;
  logic [DW-1:0] out_value, out_value4;
  logic          busy, busy4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  argmax_serializer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .INDEX_WIDTH(IW),
                      .CELL_AMOUNT(CA), .SHIFT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_enable(out_enable), .out_index(out_index),
    .out_value(out_value), .busy(busy));

  argmax_serializer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .INDEX_WIDTH(IW),
                      .CELL_AMOUNT(CA), .SHIFT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_enable(out_enable4), .out_index(out_index4),
    .out_value(out_value4), .busy(busy4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference requantizer from plain integer arithmetic.
  function automatic int quant(input logic [AW-1:0] x, input int sh);
    int s;
    s = int'($signed(x)) >>> sh;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // Behavioural model: a queue of accepted vectors (front = streaming),
  // at most two outstanding; pos = elements of the front already emitted.
  logic [CA*AW-1:0] mq[$];
  int pos = 0;
  int exp_en = 0, exp_idx = 0, exp_v8 = 0, exp_v4 = 0, exp_busy = 0, exp_ready = 1;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); pos = 0;
      exp_en = 0; exp_idx = 0; exp_v8 = 0; exp_v4 = 0; exp_busy = 0; exp_ready = 1;
    end else begin
      bit acc;
      logic [CA*AW-1:0] v;
      acc = in_valid && (mq.size() < 2);
      v   = in_data;
      if (mq.size() > 0) begin
        exp_en  = 1;
        exp_idx = pos;
        exp_v8  = quant(mq[0][pos*AW +: AW], 8);
        exp_v4  = quant(mq[0][pos*AW +: AW], 4);
        pos++;
        if (pos == CA) begin
          void'(mq.pop_front());
          pos = 0;
        end
      end else begin
        exp_en = 0; exp_idx = 0; exp_v8 = 0; exp_v4 = 0;
      end
      if (acc) mq.push_back(v);
      exp_busy  = (mq.size() > 0) ? 1 : 0;
      exp_ready = (mq.size() < 2) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cmp_en",     32'(out_enable),  32'(exp_en));
      chk("cmp_idx",    32'(out_index),   32'(exp_idx));
      chk("cmp_val",    32'(out_value),   32'(exp_v8));
      chk("cmp_busy",   32'(busy),        32'(exp_busy));
      chk("cmp_ready",  32'(in_ready),    32'(exp_ready));
      chk("cmp4_en",    32'(out_enable4), 32'(exp_en));
      chk("cmp4_idx",   32'(out_index4),  32'(exp_idx));
      chk("cmp4_val",   32'(out_value4),  32'(exp_v4));
      chk("cmp4_ready", 32'(in_ready4),   32'(exp_ready));
    end else begin
      chk("rst_en",   32'(out_enable), 32'(0));
      chk("rst_idx",  32'(out_index),  32'(0));
      chk("rst_val",  32'(out_value),  32'(0));
      chk("rst_busy", 32'(busy),       32'(0));
    end
  end

  // Offer v from a negedge; return at the negedge after the accepting edge.
  task automatic send(input logic [CA*AW-1:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'(in_ready), 32'(1));
    @(negedge clk);
  endtask

  function automatic logic [CA*AW-1:0] rand_vec();
    logic [CA*AW-1:0] v;
    logic [AW-1:0] e;
    for (int i = 0; i < CA; i++) begin
      case ($urandom_range(0, 3))
        0: e = AW'($urandom);
        1: e = AW'($urandom_range(0, 16'h1000));
        2: e = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: e = AW'(16'h0FF0 + $urandom_range(0, 32) - 16);
      endcase
      v[i*AW +: AW] = e;
    end
    return v;
  endfunction

  logic [CA*AW-1:0] va, vb, vc;
  logic [7:0] exp_single [4];
  logic [7:0] exp_sat [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_single[0] = 8'h05; exp_single[1] = 8'h12; exp_single[2] = 8'h00; exp_single[3] = 8'h00;
    exp_sat[0] = 8'hFF; exp_sat[1] = 8'hFF; exp_sat[2] = 8'hFE; exp_sat[3] = 8'h00;

    // Reset held with a vector offered: nothing may come out.
    rst_n = 1'b0; in_valid = 1'b1; in_data = rand_vec();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_en",   32'(out_enable), 32'(0));
    chk("reset_idx",  32'(out_index),  32'(0));
    chk("reset_val",  32'(out_value),  32'(0));
    chk("reset_busy", 32'(busy),       32'(0));

    // Single vector with SHIFT=8.
    rst_n = 1'b1;
    in_data = {16'h0080, 16'hFF00, 16'h1234, 16'h0500};
    #1;
    chk("post_reset_ready", 32'(in_ready), 32'(1));
    @(negedge clk);  // accepted at edge N
    in_valid = 1'b0;
    chk("lat_en_before", 32'(out_enable), 32'(0));
    chk("lat_busy",      32'(busy),       32'(1));
    for (int k = 0; k < CA; k++) begin
      @(negedge clk);
      chk("single_en",  32'(out_enable), 32'(1));
      chk("single_idx", 32'(out_index),  32'(k));
      chk("single_val", 32'(out_value),  32'(exp_single[k]));
    end
    @(negedge clk);
    chk("single_done_en",   32'(out_enable), 32'(0));
    chk("single_done_busy", 32'(busy),       32'(0));

    // Saturation on the SHIFT=4 instance.
    send({16'h8000, 16'h0FE0, 16'h0FF0, 16'h7FFF});
    in_valid = 1'b0;
    for (int k = 0; k < CA; k++) begin
      @(negedge clk);
      chk("sat_idx", 32'(out_index4), 32'(k));
      chk("sat_val", 32'(out_value4), 32'(exp_sat[k]));
    end
    repeat (3) @(negedge clk);

    // Back-to-back A, B, C with in_valid held high.
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    send(va);
    send(vb);
    chk("b2b_ready_low", 32'(in_ready), 32'(0));
    fork
      begin
        send(vc);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3*CA; k++) begin
          chk("b2b_en",  32'(out_enable), 32'(1));
          chk("b2b_idx", 32'(out_index),  32'(k % CA));
          @(negedge clk);
        end
      end
    join
    repeat (6) @(negedge clk);

    // B offered exactly on A's last-element cycle.
    send(rand_vec());
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(rand_vec());
    in_valid = 1'b0;
    chk("last_acc_idx3",  32'(out_index), 32'(3));
    chk("last_acc_ready", 32'(in_ready),  32'(1));
    @(negedge clk);
    chk("last_acc_en0",  32'(out_enable), 32'(1));
    chk("last_acc_idx0", 32'(out_index),  32'(0));
    repeat (6) @(negedge clk);

    // Reset mid-frame after A's index 1 with B pending.
    send(rand_vec());
    send(rand_vec());
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_idx1", 32'(out_index), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en",   32'(out_enable), 32'(0));
    chk("mid_rst_idx",  32'(out_index),  32'(0));
    chk("mid_rst_val",  32'(out_value),  32'(0));
    chk("mid_rst_busy", 32'(busy),       32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'(1));
    chk("mid_rel_busy",  32'(busy),     32'(0));
    repeat (8) begin
      @(negedge clk);
      chk("mid_no_resume", 32'(out_enable), 32'(0));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = rand_vec();
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
